unified_mem_ctrl: RTL and testbench
===================================

Name: unified_mem_ctrl

Overview:
Parametrised single-ported unified memory controller that replaces the separate combinational instruction and data memories for the multi-cycle/pipelined CPU generation. It arbitrates between an instruction-fetch read port and a data read/write port onto one internal word array. Access latency is configurable through wait states. Completion uses a req/ack handshake, with error reporting for misaligned or out-of-range addresses.

Parameters:
DATA_W, 64, data word width in bits; power of two, at least 64.
INST_W, 32, instruction width; DATA_W is an integer multiple of INST_W.
ADDR_W, 64, byte-address width of both ports.
DEPTH, 1024, number of DATA_W words in the array; power of two.
LATENCY, 2, wait-state cycles per access, range 0..15.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
i_req  in  1  instruction fetch request; level, held until i_ack.
i_addr  in  ADDR_W  fetch byte address; stable while i_req is high.
i_ack  out  1  one-cycle fetch completion pulse.
i_rdata  out  INST_W  fetched instruction; valid while i_ack is high.
i_err  out  1  fetch error; valid with i_ack.
d_req  in  1  data request; level, held until d_ack.
d_we  in  1  1 = write, 0 = read; stable with d_req.
d_addr  in  ADDR_W  data byte address.
d_wdata  in  DATA_W  write data.
d_ack  out  1  one-cycle data completion pulse.
d_rdata  out  DATA_W  read data; valid while d_ack is high.
d_err  out  1  data error; valid with d_ack.
busy  out  1  high when not in IDLE.

Behaviour:
- Reset: FSM goes to IDLE. i_ack, d_ack, i_err, d_err, busy = 0. i_rdata and d_rdata = 0. The last-grant flag is set to INST, so data wins the first tie. Array contents are preserved.
- Reset mid-operation: the access is aborted. No write occurs if the ACCESS completion cycle has not been reached. No ack is issued.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise grant a port, latch its addr/we/wdata, load cnt = LATENCY, go to ACCESS.
- ACCESS:
  - While cnt != 0, decrement cnt.
  - When cnt == 0, perform the access (array read or write), register the response, go to RESP.
- RESP: assert ack, rdata and err for the granted port for exactly one cycle, then go to IDLE.
- Latency: a request sampled in IDLE at cycle t produces its ack at cycle t + LATENCY + 2. With LATENCY=0, ack arrives at t+2.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port not granted last (round-robin). The last-grant flag updates on each grant.
  - Ports never starve.
- Requester rule: req must be low in the cycle after ack unless a new request is intended. IDLE samples req in that cycle.
- Addressing: word index = addr[log2(DATA_W/8) +: log2(DEPTH)]. Out-of-range means any address bit above that field is set.
- Fetch alignment and data return:
  - Fetches must be INST_W/8-byte aligned.
  - i_rdata = INST_W slice of the word selected by addr[log2(DATA_W/8)-1 : log2(INST_W/8)]. Slice 0 is least significant.
- Data alignment: data accesses must be DATA_W/8-byte aligned.
- Error cases (misaligned or out-of-range):
  - ack is still issued with err=1 and rdata=0.
  - Writes are suppressed; the array is unchanged.
  - Latency is identical to a normal access.
- Read-after-write: a data read granted after a write ack returns the new value.
- Simultaneous writes: none are possible (single port).
- Fetch-vs-write ordering: a fetch of a word being written returns old data if granted first, and new data otherwise.
- Outside ack cycles: i_rdata/d_rdata hold 0; err outputs are 0.
- Unused write fields: d_we and d_wdata are ignored when d_req is low. No initialisation file; the bench preloads via writes.

Test Plan:
- LATENCY=2, d write 0xDEADBEEF_01234567 to addr 0x10; then d read 0x10. Required: each d_ack 4 cycles after grant; read returns 0xDEADBEEF_01234567; d_err=0.
- After the above, fetch 0x10 and 0x14. Required: i_rdata 0x01234567 then 0xDEADBEEF; i_err=0.
- i_req and d_req both high continuously with fresh addresses, starting right after reset. Required: grants alternate D, I, D, I; no port waits for more than one other access.
- d write to addr 0x2000 (DEPTH=1024, out of range) and to 0x13 (misaligned). Required: d_ack with d_err=1 and d_rdata=0; subsequent reads of 0x0 and 0x10 show unchanged data.
- LATENCY=0: d read issued back-to-back. Required: acks every 3 cycles; busy low only in the IDLE cycles.
- rst asserted for 1 cycle while in ACCESS on a write with cnt=1. Required: no ack; all outputs 0; the target word keeps its old value; the next request completes normally.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: single-ported word array shared by an instruction-fetch
// read port and a data read/write port. Accesses are arbitrated round-robin.
// Each access spends LATENCY wait states in ACCESS and then answers with a
// one-cycle ack pulse. Misaligned or out-of-range addresses still receive an
// ack, with err=1 and rdata=0, and never modify the array.
module unified_mem_ctrl #(
    parameter int DATA_W  = 64,
    parameter int INST_W  = 32,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [INST_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              busy
);

    localparam int OFF_W  = $clog2(DATA_W / 8);   // byte offset within a word
    localparam int IDX_W  = $clog2(DEPTH);        // word index width
    localparam int IOFF_W = $clog2(INST_W / 8);   // byte offset within an instruction
    localparam int NSLICE = DATA_W / INST_W;      // instructions per word

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              gnt_d_reg;     // 1 = current access belongs to the data port
    logic              last_i_reg;    // 1 = the most recent grant went to the fetch port
    logic              we_reg;
    logic              err_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [OFF_W-1:0]  off_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              i_ack_reg;
    logic              d_ack_reg;
    logic              i_err_reg;
    logic              d_err_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_reg;

    // Grant decision and address checks for the request seen in IDLE
    logic              pick_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;
    logic              access_done;
    logic              mem_we;

    // Data wins when it is the only requester or when fetch was granted last
    always_comb begin
        pick_d   = d_req && (!i_req || last_i_reg);
        sel_addr = pick_d ? d_addr : i_addr;
        sel_err  = ((sel_addr >> (OFF_W + IDX_W)) != '0) ||
                   (pick_d ? ((d_addr & ADDR_W'(DATA_W / 8 - 1)) != '0)
                           : ((i_addr & ADDR_W'(INST_W / 8 - 1)) != '0));
    end

    // The write is gated by rst, so a reset in the completion cycle cancels it
    assign access_done = (state_reg == ST_ACCESS) && (cnt_reg == 4'd0);
    assign mem_we      = access_done && we_reg && !err_reg && !rst;

    // Array port: write on completion, registered read of the addressed word
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_reg] <= wdata_reg;
        end
        if (access_done) begin
            rd_word_reg <= mem[idx_reg];
        end
    end

    // Control FSM: IDLE grants, ACCESS counts wait states, RESP pulses ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 4'd0;
            gnt_d_reg  <= 1'b0;
            last_i_reg <= 1'b1;
            we_reg     <= 1'b0;
            err_reg    <= 1'b0;
            idx_reg    <= '0;
            off_reg    <= '0;
            wdata_reg  <= '0;
            i_ack_reg  <= 1'b0;
            d_ack_reg  <= 1'b0;
            i_err_reg  <= 1'b0;
            d_err_reg  <= 1'b0;
        end else begin
            i_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            i_err_reg <= 1'b0;
            d_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        gnt_d_reg  <= pick_d;
                        last_i_reg <= !pick_d;
                        we_reg     <= pick_d && d_we;
                        err_reg    <= sel_err;
                        idx_reg    <= sel_addr[OFF_W +: IDX_W];
                        off_reg    <= sel_addr[OFF_W-1:0];
                        wdata_reg  <= d_wdata;
                        cnt_reg    <= 4'(LATENCY);
                        state_reg  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        i_ack_reg <= !gnt_d_reg;
                        d_ack_reg <= gnt_d_reg;
                        i_err_reg <= !gnt_d_reg && err_reg;
                        d_err_reg <= gnt_d_reg && err_reg;
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Split the read word into instruction-sized slices, slice 0 least significant
    logic [INST_W-1:0] slice_w [NSLICE];
    logic [OFF_W-1:0]  slice_sel;
    logic [INST_W-1:0] inst_word;

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        assign slice_w[gi] = rd_word_reg[gi*INST_W +: INST_W];
    end

    assign slice_sel = off_reg >> IOFF_W;

    // Pick the slice addressed by the fetch offset
    always_comb begin
        inst_word = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (slice_sel == OFF_W'(k)) begin
                inst_word = slice_w[k];
            end
        end
    end

    // Read data is only driven during a successful ack; writes return zero
    assign i_ack   = i_ack_reg;
    assign d_ack   = d_ack_reg;
    assign i_err   = i_err_reg;
    assign d_err   = d_err_reg;
    assign i_rdata = (i_ack_reg && !i_err_reg) ? inst_word : '0;
    assign d_rdata = (d_ack_reg && !d_err_reg && !we_reg) ? rd_word_reg : '0;
    assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Testbench for unified_mem_ctrl: directed steps plus randomized traffic
// checked against an associative-array memory model. A second instance
// with LATENCY=0 covers back-to-back timing.
module tb_unified_mem_ctrl;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_req, i_ack, i_err, d_req, d_we, d_ack, d_err, busy;
    logic [63:0] i_addr, d_addr, d_wdata, d_rdata;
    logic [31:0] i_rdata;

    logic        z_i_req, z_i_ack, z_i_err, z_d_req, z_d_we, z_d_ack, z_d_err, z_busy;
    logic [63:0] z_i_addr, z_d_addr, z_d_wdata, z_d_rdata;
    logic [31:0] z_i_rdata;

    unified_mem_ctrl #(.DATA_W(64), .INST_W(32), .ADDR_W(64), .DEPTH(1024), .LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
    );

    unified_mem_ctrl #(.DATA_W(64), .INST_W(32), .ADDR_W(64), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata), .i_err(z_i_err),
        .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
        .d_ack(z_d_ack), .d_rdata(z_d_rdata), .d_err(z_d_err), .busy(z_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory keyed by word index (byte address / 8)
    logic [63:0] ref_mem [int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit data_bad(input logic [63:0] a);
        return ((a / 8) >= 1024) || ((a % 8) != 0);
    endfunction

    function automatic bit fetch_bad(input logic [63:0] a);
        return ((a / 8) >= 1024) || ((a % 4) != 0);
    endfunction

    // One data transaction; starts and ends on a falling edge
    task automatic d_xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rd, output logic er, output int lat);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_ack && lat < 40);
        check("d_ack_seen", 64'(d_ack), 64'(1));
        rd = d_rdata; er = d_err;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic i_xact(input logic [63:0] addr, output logic [31:0] rd, output logic er,
                          output int lat);
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!i_ack && lat < 40);
        check("i_ack_seen", 64'(i_ack), 64'(1));
        rd = i_rdata; er = i_err;
        i_req = 1'b0; i_addr = '0;
    endtask

    task automatic do_data(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                           input string tag);
        logic [63:0] rd;
        logic        er;
        int          lat;
        bit          bad;
        int          idx;
        bad = data_bad(addr);
        idx = int'((addr / 8) % 1024);
        d_xact(we, addr, wdata, rd, er, lat);
        $display("DATA %s we=%0d addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
                 tag, we, addr, wdata, rd, er, lat);
        check({tag, "_lat"}, 64'(lat), 64'(L + 2));
        check({tag, "_err"}, 64'(er), 64'(bad));
        if (bad) check({tag, "_rdata_zero"}, rd, 64'(0));
        else if (we) ref_mem[idx] = wdata;
        else check({tag, "_rdata"}, rd, ref_mem[idx]);
    endtask

    task automatic do_fetch(input logic [63:0] addr, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          bad;
        logic [63:0] word;
        logic [31:0] exp;
        bad = fetch_bad(addr);
        i_xact(addr, rd, er, lat);
        $display("FETCH %s addr=%h rdata=%h err=%0b lat=%0d", tag, addr, rd, er, lat);
        check({tag, "_lat"}, 64'(lat), 64'(L + 2));
        check({tag, "_err"}, 64'(er), 64'(bad));
        if (bad) begin
            exp = '0;
        end else begin
            word = ref_mem[int'(addr / 8)];
            exp  = 32'(word >> (32 * ((addr / 4) % 2)));
        end
        check({tag, "_rdata"}, 64'(rd), 64'(exp));
    endtask

    initial begin : main
        logic [63:0] oldv, newv, a;
        logic [63:0] ia, da;
        logic        exp_d, any_ack;
        int          n, cyc, last_cyc, op, idx;

        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        z_i_req = 0; z_i_addr = 0; z_d_req = 0; z_d_we = 0; z_d_addr = 0; z_d_wdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({i_ack, d_ack, i_err, d_err, busy}), 64'(0));
        check("reset_rdata", d_rdata | 64'(i_rdata), 64'(0));
        rst = 1'b0;

        // Preload a pool of 16 words
        for (int k = 0; k < 16; k++)
            do_data(1'b1, 64'(k * 8), {$urandom, $urandom}, "preload");

        // Write then read back at 0x10, then fetch both halves
        do_data(1'b1, 64'h10, 64'hDEADBEEF_01234567, "wr10");
        do_data(1'b0, 64'h10, 64'h0, "rd10");
        check("rd10_const", ref_mem[2], 64'hDEADBEEF_01234567);
        do_fetch(64'h10, "f10");
        do_fetch(64'h14, "f14");

        // Error writes leave the array untouched
        do_data(1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, "oor_wr");
        do_data(1'b1, 64'h13, 64'hAAAA_5555_AAAA_5555, "mis_wr");
        do_data(1'b0, 64'h0, 64'h0, "rd0_after_err");
        do_data(1'b0, 64'h10, 64'h0, "rd10_after_err");

        // Randomized traffic over the pool, including error addresses
        for (int t = 0; t < 40; t++) begin
            op  = int'($urandom_range(0, 4));
            idx = int'($urandom_range(0, 15));
            case (op)
                0: do_data(1'b1, 64'(idx * 8), {$urandom, $urandom}, "rnd_wr");
                1: do_data(1'b0, 64'(idx * 8), 64'h0, "rnd_rd");
                2: do_fetch(64'(idx * 8 + 4 * int'($urandom_range(0, 1))), "rnd_fetch");
                3: begin
                    if ($urandom_range(0, 1) == 1)
                        a = 64'(idx * 8 + int'($urandom_range(1, 7)));
                    else
                        a = 64'(idx * 8) | (64'(1) << (13 + $urandom_range(0, 50)));
                    do_data(1'(($urandom_range(0, 1))), a, {$urandom, $urandom}, "rnd_bad_d");
                end
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        a = 64'(idx * 8 + int'($urandom_range(1, 3)));
                    else
                        a = 64'(idx * 8) | (64'(1) << (13 + $urandom_range(0, 50)));
                    do_fetch(a, "rnd_bad_f");
                end
            endcase
        end

        // Reset while a write is in ACCESS with one wait state left
        oldv = ref_mem[5];
        newv = ~oldv;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h28; d_wdata = newv;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(1));
        rst = 1'b1; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        @(negedge clk);
        check("midrst_ctrl", 64'({i_ack, d_ack, i_err, d_err, busy}), 64'(0));
        check("midrst_rdata", d_rdata | 64'(i_rdata), 64'(0));
        rst = 1'b0;
        any_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_ack = any_ack | d_ack | i_ack;
        end
        check("midrst_no_ack", 64'(any_ack), 64'(0));
        do_data(1'b0, 64'h28, 64'h0, "midrst_old");
        $display("MIDRST addr=28 kept=%h", oldv);

        // Both ports requesting continuously from reset: D, I, D, I ...
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ia = 64'h0; da = 64'h40;
        i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = da;
        exp_d = 1'b1; n = 0; cyc = 0; last_cyc = 0;
        while (n < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_ack || i_ack) begin
                $display("ARB ack#%0d cyc=%0d d_ack=%0b i_ack=%0b d_rdata=%h i_rdata=%h",
                         n, cyc, d_ack, i_ack, d_rdata, i_rdata);
                check("arb_single_ack", 64'(d_ack & i_ack), 64'(0));
                check("arb_order", 64'(d_ack), 64'(exp_d));
                check("arb_gap", 64'(cyc - last_cyc), 64'((n == 0) ? (L + 2) : (L + 3)));
                if (d_ack) begin
                    check("arb_d_rdata", d_rdata, ref_mem[int'(da / 8)]);
                    da = 64'(((da / 8 + 1) % 16) * 8);
                    d_addr = da;
                end else begin
                    check("arb_i_rdata", 64'(i_rdata),
                          64'(32'(ref_mem[int'(ia / 8)] >> (32 * ((ia / 4) % 2)))));
                    ia = (ia + 4) % 128;
                    i_addr = ia;
                end
                exp_d = !exp_d;
                last_cyc = cyc;
                n++;
            end
        end
        check("arb_count", 64'(n), 64'(8));
        i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        repeat (4) @(negedge clk);

        // LATENCY=0 instance: preload one word, then back-to-back reads
        newv = {$urandom, $urandom};
        z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 64'h18; z_d_wdata = newv;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!z_d_ack && cyc < 40);
        check("l0_wr_lat", 64'(cyc), 64'(2));
        z_d_req = 1'b0; z_d_we = 1'b0; z_d_wdata = '0;
        @(negedge clk);
        z_d_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check("l0_busy", 64'(z_busy), 64'((c % 3) != 0));
            check("l0_ack", 64'(z_d_ack), 64'((c % 3) == 2));
            if (z_d_ack) begin
                $display("L0 read cyc=%0d rdata=%h err=%0b", c, z_d_rdata, z_d_err);
                check("l0_rdata", z_d_rdata, newv);
                check("l0_err", 64'(z_d_err), 64'(0));
            end
            if (c == 11) z_d_req = 1'b0;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
